// File: rtl/hwpe_stream_tcdm_load_fifo.sv
// hwpe_stream_tcdm_load_fifo
// Credit-controlled load path: forwards load requests to TCDM only when the
// response buffer is guaranteed to have room, buffers returned read data and
// presents it as a 32-bit stream.
// Optional build macro: HWPE_STREAM_TCDM_LOAD_FIFO_BYPASS_EN -- when defined,
// a response arriving at an empty buffer is shown on the stream in the same
// cycle (and only stored if the consumer is not ready).
module hwpe_stream_tcdm_load_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          slv_req_i,
  output logic                          slv_gnt_o,
  input  logic [31:0]                   slv_add_i,
  output logic                          mst_req_o,
  input  logic                          mst_gnt_i,
  output logic [31:0]                   mst_add_o,
  output logic                          mst_wen_o,
  output logic [3:0]                    mst_be_o,
  output logic [31:0]                   mst_data_o,
  input  logic [31:0]                   mst_r_data_i,
  input  logic                          mst_r_valid_i,
  output logic                          stream_valid_o,
  input  logic                          stream_ready_i,
  output logic [31:0]                   stream_data_o,
  output logic [3:0]                    stream_strb_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_inflight;

  logic [CW:0]   w_occ;
  logic          w_credit_ok;
  logic          w_accept;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Load-only master: constant write-side signals and full-word strobe.
  assign mst_wen_o     = 1'b1;
  assign mst_be_o      = 4'h0;
  assign mst_data_o    = 32'h0;
  assign stream_strb_o = 4'hF;
  assign mst_add_o     = slv_add_i;

  // A slot is reserved for the response still in flight, so a grant is only
  // possible while buffered + in-flight stays below the depth.
  assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_credit_ok = (w_occ < (CW+1)'(FIFO_DEPTH));
  assign mst_req_o   = slv_req_i & w_credit_ok;
  assign slv_gnt_o   = mst_gnt_i & w_credit_ok;

  // Stray read-valids with nothing outstanding are ignored.
  assign w_accept = mst_r_valid_i & r_inflight;
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty & stream_ready_i;
  assign count_o  = r_count;
  assign empty_o  = w_empty;

`ifdef HWPE_STREAM_TCDM_LOAD_FIFO_BYPASS_EN
  logic w_bypass;
  assign w_bypass       = w_empty & w_accept;
  assign w_push         = w_accept & ~(w_bypass & stream_ready_i);
  assign stream_valid_o = ~w_empty | w_bypass;
  assign stream_data_o  = w_bypass ? mst_r_data_i : r_mem[r_rptr];
`else
  assign w_push         = w_accept;
  assign stream_valid_o = ~w_empty;
  assign stream_data_o  = r_mem[r_rptr];
`endif

  // Response storage, written at the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push && !clear_i) begin
      r_mem[r_wptr] <= mst_r_data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TCDM answers exactly one cycle after grant, so one flag tracks it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
    end else if (clear_i) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= mst_req_o & mst_gnt_i;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_fifo.sv
// Bench for hwpe_stream_tcdm_load_fifo: queue-based reference model,
// directed scenarios plus a randomized run. Honours
// HWPE_STREAM_TCDM_LOAD_FIFO_BYPASS_EN like the design.
module tb_hwpe_stream_tcdm_load_fifo;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0, req = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0]   add = '0, rdata = '0;
  logic          slv_gnt_o, mst_req_o, mst_wen_o, stream_valid_o, empty_o;
  logic [31:0]   mst_add_o, mst_data_o, stream_data_o;
  logic [3:0]    mst_be_o, stream_strb_o;
  logic [CW-1:0] count_o;

  hwpe_stream_tcdm_load_fifo #(.FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .slv_req_i(req), .slv_gnt_o(slv_gnt_o), .slv_add_i(add),
    .mst_req_o(mst_req_o), .mst_gnt_i(gnt), .mst_add_o(mst_add_o),
    .mst_wen_o(mst_wen_o), .mst_be_o(mst_be_o), .mst_data_o(mst_data_o),
    .mst_r_data_i(rdata), .mst_r_valid_i(rvalid),
    .stream_valid_o(stream_valid_o), .stream_ready_i(ready),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // The buffer must never exceed its depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count_o <= CW'(D));

  int n_vec = 0, n_err = 0;

  // Reference model: buffered responses as a queue, plus outstanding flag.
  logic [31:0] q[$];
  bit          infl = 0;
  bit          e_req, e_gnt, e_valid, e_push, e_pop;
  logic [31:0] e_data;

  function void predict();
    int cnt;
    bit acc;
    cnt     = q.size();
    e_req   = req && ((cnt + int'(infl)) < D);
    e_gnt   = gnt && ((cnt + int'(infl)) < D);
    acc     = rvalid && infl;
    e_valid = (cnt > 0);
    e_data  = (cnt > 0) ? q[0] : 32'h0;
    e_pop   = (cnt > 0) && ready;
    e_push  = acc;
`ifdef HWPE_STREAM_TCDM_LOAD_FIFO_BYPASS_EN
    if (cnt == 0 && acc) begin
      e_valid = 1'b1;
      e_data  = rdata;
      e_push  = !ready;
    end
`endif
  endfunction

  task automatic commit();
    @(posedge clk);
    if (clr) begin
      q.delete();
      infl = 0;
    end else begin
      if (e_pop)  void'(q.pop_front());
      if (e_push) q.push_back(rdata);
      infl = e_req && gnt;
    end
  endtask

  task automatic idle();
    req = 0; gnt = 0; rvalid = 0; ready = 0; clr = 0; rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    q.delete();
    infl = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; idle(); q.delete(); infl = 0;
    req = 1; add = $urandom;
    #1;
    n_vec++;
    if ({mst_wen_o, mst_be_o, mst_data_o, stream_strb_o} !== {1'b1, 4'h0, 32'h0, 4'hF}) begin
      n_err++; $display("FAIL reset_ties: got %b %h %h %h", mst_wen_o, mst_be_o, mst_data_o, stream_strb_o);
    end
    n_vec++;
    if ({count_o, empty_o, stream_valid_o} !== {CW'(0), 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_state: count=%0d empty=%b valid=%b, want 0 1 0", count_o, empty_o, stream_valid_o);
    end
    n_vec++;
    if (mst_req_o !== 1'b1 || mst_add_o !== add) begin
      n_err++; $display("FAIL reset_fwd: req=%b add=%h, want 1 %h", mst_req_o, mst_add_o, add);
    end
    @(negedge clk);
    idle(); rst_n = 1;
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk);
    req = 1; add = 32'h100; gnt = 1; ready = 1; #1 predict();
    n_vec++;
    if ({mst_req_o, slv_gnt_o} !== 2'b11 || mst_add_o !== 32'h100) begin
      n_err++; $display("FAIL lat_grant: req=%b gnt=%b add=%h, want 1 1 100", mst_req_o, slv_gnt_o, mst_add_o);
    end
    commit();
    @(negedge clk);
    req = 0; rvalid = 1; rdata = 32'hDEADBEEF; #1 predict();
    n_vec++;
`ifdef HWPE_STREAM_TCDM_LOAD_FIFO_BYPASS_EN
    if (stream_valid_o !== 1'b1 || stream_data_o !== 32'hDEADBEEF || count_o !== CW'(0)) begin
`else
    if (stream_valid_o !== 1'b0 || count_o !== CW'(0)) begin
`endif
      n_err++; $display("FAIL lat_cyc1: valid=%b data=%h count=%0d", stream_valid_o, stream_data_o, count_o);
    end
    commit();
    @(negedge clk);
    rvalid = 0; #1 predict();
    n_vec++;
`ifdef HWPE_STREAM_TCDM_LOAD_FIFO_BYPASS_EN
    if (stream_valid_o !== 1'b0 || count_o !== CW'(0)) begin
`else
    if (stream_valid_o !== 1'b1 || stream_data_o !== 32'hDEADBEEF || count_o !== CW'(1)) begin
`endif
      n_err++; $display("FAIL lat_cyc2: valid=%b data=%h count=%0d", stream_valid_o, stream_data_o, count_o);
    end
    commit();
    idle();
  endtask

  task automatic test_credit();
    int g = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req = 1; gnt = 1; ready = 0; rvalid = infl; rdata = 32'(c); #1 predict();
      if (slv_gnt_o) g++;
      commit();
    end
    @(negedge clk); #1;
    n_vec++;
    if (g != 4 || slv_gnt_o !== 1'b0 || count_o !== CW'(4)) begin
      n_err++; $display("FAIL credit_fill: grants=%0d gnt=%b count=%0d, want 4 0 4", g, slv_gnt_o, count_o);
    end
    g = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = 1; gnt = 1; ready = (c == 0); rvalid = infl; rdata = 32'(c); #1 predict();
      if (slv_gnt_o) g++;
      commit();
    end
    n_vec++;
    if (g != 1) begin
      n_err++; $display("FAIL credit_refill: grants=%0d, want 1", g);
    end
    idle();
  endtask

  task automatic test_order();
    logic [31:0] got[$];
    int g = 0, r = 0, cyc = 0;
    do_reset();
    while (got.size() < 6 && cyc < 200) begin
      @(negedge clk);
      req = (g < 6); gnt = 1; ready = 1'($urandom_range(0, 1));
      rvalid = infl; rdata = 32'(r + 1); #1 predict();
      n_vec++;
      if (stream_valid_o !== e_valid || (e_valid && stream_data_o !== e_data)) begin
        n_err++; $display("FAIL order_cyc: valid=%b data=%h, want %b %h", stream_valid_o, stream_data_o, e_valid, e_data);
      end
      if (stream_valid_o && ready) got.push_back(stream_data_o);
      if (e_req && gnt) g++;
      if (rvalid) r++;
      commit();
      cyc++;
    end
    n_vec++;
    if (got.size() != 6) begin
      n_err++; $display("FAIL order_count: popped %0d, want 6", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== 32'(i + 1)) begin
        n_err++; $display("FAIL order_seq[%0d]: got %0d want %0d", i, got[i], i + 1);
      end
    end
    idle();
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = (c < 3); gnt = 1; ready = (c == 3); rvalid = infl;
      rdata = 32'hA0 + 32'(c); #1 predict();
      commit();
    end
    @(negedge clk); idle(); #1;
    n_vec++;
    if (count_o !== CW'(2) || stream_data_o !== 32'hA2) begin
      n_err++; $display("FAIL push_pop: count=%0d head=%h, want 2 a2", count_o, stream_data_o);
    end
  endtask

  task automatic test_clear();
    do_reset();
    @(negedge clk); req = 1; gnt = 1; #1 predict(); commit();
    @(negedge clk); rvalid = 1; rdata = 32'h11; #1 predict(); commit();
    @(negedge clk); rdata = 32'h22; #1 predict(); commit();
    @(negedge clk);
    clr = 1; rdata = 32'h33; #1 predict();
    n_vec++;
    if (mst_req_o !== 1'b1) begin
      n_err++; $display("FAIL clear_fwd: mst_req=%b, want 1", mst_req_o);
    end
    commit();
    @(negedge clk);
    clr = 0; req = 0; rdata = 32'h44; #1 predict(); commit();
    @(negedge clk); idle(); #1;
    n_vec++;
    if (count_o !== CW'(0) || empty_o !== 1'b1 || stream_valid_o !== 1'b0) begin
      n_err++; $display("FAIL clear_drop: count=%0d empty=%b valid=%b, want 0 1 0", count_o, empty_o, stream_valid_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = (c < 3); gnt = 1; rvalid = infl; rdata = 32'(c + 10); #1 predict();
      commit();
    end
    @(negedge clk); idle(); #1;
    n_vec++;
    if (count_o !== CW'(3)) begin
      n_err++; $display("FAIL areset_pre: count=%0d, want 3", count_o);
    end
    #1 rst_n = 0;
    #1;
    n_vec++;
    if ({count_o, empty_o, stream_valid_o} !== {CW'(0), 1'b1, 1'b0}) begin
      n_err++; $display("FAIL areset_now: count=%0d empty=%b valid=%b, want 0 1 0", count_o, empty_o, stream_valid_o);
    end
    q.delete(); infl = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1)); gnt = 1'($urandom_range(0, 3) != 0);
      ready = 1'($urandom_range(0, 2) == 0); add = $urandom;
      rvalid = infl ? 1'b1 : 1'($urandom_range(0, 7) == 0);
      rdata = $urandom; clr = 1'($urandom_range(0, 31) == 0);
      #1 predict();
      n_vec++;
      if ({mst_req_o, slv_gnt_o, stream_valid_o, empty_o, count_o} !==
          {e_req, e_gnt, e_valid, 1'(q.size() == 0), CW'(q.size())}) begin
        n_err++; $display("FAIL rand_ctl@%0d: req=%b gnt=%b valid=%b empty=%b count=%0d, want %b %b %b %0d",
                          c, mst_req_o, slv_gnt_o, stream_valid_o, empty_o, count_o, e_req, e_gnt, e_valid, q.size());
      end
      if (e_valid) begin
        n_vec++;
        if (stream_data_o !== e_data || mst_add_o !== add) begin
          n_err++; $display("FAIL rand_data@%0d: data=%h add=%h, want %h %h", c, stream_data_o, mst_add_o, e_data, add);
        end
      end
      commit();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_credit();
    test_order();
    test_push_pop();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
